// File: rtl/lcd_cmd_arb.sv
// lcd_cmd_arb: two-host round-robin command arbiter/sequencer for the 6x6 LCD
// display controller. Issues one command at a time on lcd_cmd/lcd_cmd_valid,
// streams the owner's 36-byte image from the shared image memory for Load,
// and routes the controller's display window back to the owning host.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req0/1, cmd0/1        level requests with 3-bit command codes
//   ack0/1, err0/1, done0/1  one-cycle status pulses per requester
//   out_valid0/1, out_data   display bytes routed to the owner
//   mem_sel, mem_addr, mem_rdata  image memory read port (bank = owner)
//   lcd_cmd, lcd_cmd_valid, lcd_datain  controller command/data
//   lcd_busy, lcd_dataout, lcd_output_valid  controller status/display
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | arbitrate when controller idle; illegal commands rejected here
// S_ISSUE     | one-cycle command strobe and ack to the owner
// S_LOAD      | stream IMG_BYTES image bytes from the owner's bank
// S_WAIT_BUSY | wait for the controller to raise busy after a non-Load command
// S_WAIT_DONE | wait for busy to fall, then report done (and err if short)
module lcd_cmd_arb #(
   parameter int IMG_BYTES = 36,
   parameter int WIN_BYTES = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [2:0] cmd0,
   input  logic [2:0] cmd1,
   output logic       ack0,
   output logic       ack1,
   output logic       err0,
   output logic       err1,
   output logic       done0,
   output logic       done1,
   output logic       out_valid0,
   output logic       out_valid1,
   output logic [7:0] out_data,
   output logic       mem_sel,
   output logic [5:0] mem_addr,
   input  logic [7:0] mem_rdata,
   output logic [2:0] lcd_cmd,
   output logic       lcd_cmd_valid,
   output logic [7:0] lcd_datain,
   input  logic       lcd_busy,
   input  logic [7:0] lcd_dataout,
   input  logic       lcd_output_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_LOAD,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   localparam logic [5:0] LAST_ADDR = 6'(IMG_BYTES - 1);
   localparam logic [3:0] WIN_CNT   = 4'(WIN_BYTES);
   localparam logic [2:0] CMD_LOAD  = 3'd1;

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic [2:0] cmd_q, cmd_d;
   logic       cmd_valid_q, cmd_valid_d;
   logic [1:0] ack_q, ack_d;
   logic [1:0] err_q, err_d;
   logic [1:0] done_q, done_d;
   logic [5:0] addr_q, addr_d;
   logic [3:0] count_q, count_d;

   logic       in_xfer;
   logic       routed;
   logic [3:0] count_inc;
   logic       win;
   logic [2:0] win_cmd;

   always_comb begin
      in_xfer   = (state_q == S_LOAD) || (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
      routed    = lcd_output_valid & in_xfer;
      count_inc = (routed && (count_q != 4'hF)) ? count_q + 4'd1 : count_q;
      win       = (req0 & req1) ? ~last_q : req1;
      win_cmd   = win ? cmd1 : cmd0;

      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cmd_d       = cmd_q;
      cmd_valid_d = 1'b0;
      ack_d       = 2'b00;
      err_d       = 2'b00;
      done_d      = 2'b00;
      addr_d      = addr_q;
      count_d     = count_inc;

      case (state_q)
         S_IDLE: begin
            // Skip the cycle in which an ack/done pulse is visible: the host
            // has not had a chance to drop or change its request yet.
            if (!lcd_busy && (ack_q == 2'b00) && (done_q == 2'b00) && (req0 | req1)) begin
               ack_d[win] = 1'b1;
               if (win_cmd[2:1] == 2'b11) begin
                  err_d[win] = 1'b1;
                  last_d     = win;
               end else begin
                  owner_d     = win;
                  cmd_d       = win_cmd;
                  cmd_valid_d = 1'b1;
                  state_d     = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            addr_d  = 6'd0;
            state_d = (cmd_q == CMD_LOAD) ? S_LOAD : S_WAIT_BUSY;
         end
         S_LOAD: begin
            if (addr_q == LAST_ADDR) begin
               addr_d  = 6'd0;
               state_d = S_WAIT_DONE;
            end else begin
               addr_d = addr_q + 6'd1;
            end
         end
         S_WAIT_BUSY: begin
            if (lcd_busy) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (!lcd_busy) begin
               done_d[owner_q] = 1'b1;
               err_d[owner_q]  = (count_inc != WIN_CNT);
               last_d          = owner_q;
               count_d         = 4'd0;
               state_d         = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         cmd_q       <= 3'd0;
         cmd_valid_q <= 1'b0;
         ack_q       <= 2'b00;
         err_q       <= 2'b00;
         done_q      <= 2'b00;
         addr_q      <= 6'd0;
         count_q     <= 4'd0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         done_q      <= done_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
      end
   end

   assign ack0          = ack_q[0];
   assign ack1          = ack_q[1];
   assign err0          = err_q[0];
   assign err1          = err_q[1];
   assign done0         = done_q[0];
   assign done1         = done_q[1];
   assign out_valid0    = routed & ~owner_q;
   assign out_valid1    = routed & owner_q;
   assign out_data      = lcd_dataout;
   assign mem_sel       = owner_q;
   assign mem_addr      = addr_q;
   assign lcd_cmd       = cmd_q;
   assign lcd_cmd_valid = cmd_valid_q;
   assign lcd_datain    = (state_q == S_LOAD) ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_lcd_cmd_arb.sv
// Directed testbench for lcd_cmd_arb with a simple LCD controller model and
// a combinational image memory (bank0 byte i = i, bank1 byte i = 0x40 + i).
module tb_lcd_cmd_arb;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [2:0] cmd0 = 3'd0, cmd1 = 3'd0;
   logic       ack0, ack1, err0, err1, done0, done1, out_valid0, out_valid1;
   logic [7:0] out_data;
   logic       mem_sel;
   logic [5:0] mem_addr;
   logic [7:0] mem_rdata;
   logic [2:0] lcd_cmd;
   logic       lcd_cmd_valid;
   logic [7:0] lcd_datain;
   logic       lcd_busy;
   logic [7:0] lcd_dataout;
   logic       lcd_output_valid;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lcd_cmd_arb dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .done0(done0), .done1(done1),
      .out_valid0(out_valid0), .out_valid1(out_valid1), .out_data(out_data),
      .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain),
      .lcd_busy(lcd_busy), .lcd_dataout(lcd_dataout), .lcd_output_valid(lcd_output_valid)
   );

   assign mem_rdata = mem_sel ? (8'h40 + {2'b00, mem_addr}) : {2'b00, mem_addr};

   // Controller model: busy from the accept edge; for Load it samples 36 bytes,
   // then emits win_n display bytes (first byte 0xA0 + win_n), then drops busy.
   logic       busy_force = 1'b0;
   logic       m_busy, m_ov;
   logic [7:0] m_dout;
   int         m_load_left, m_out_left;
   int         win_n = 9;
   int         ld_idx = 0;
   logic [7:0] ld_buf [0:35];

   assign lcd_busy         = m_busy | busy_force;
   assign lcd_dataout      = m_dout;
   assign lcd_output_valid = m_ov;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy      <= 1'b0;
         m_ov        <= 1'b0;
         m_dout      <= 8'h00;
         m_load_left <= 0;
         m_out_left  <= 0;
      end else if (lcd_cmd_valid && !m_busy) begin
         m_busy      <= 1'b1;
         m_load_left <= (lcd_cmd == 3'd1) ? 36 : 0;
         m_out_left  <= win_n;
         ld_idx      <= 0;
         m_ov        <= 1'b0;
      end else if (m_busy) begin
         if (m_load_left > 0) begin
            if (ld_idx < 36) ld_buf[ld_idx] <= lcd_datain;
            ld_idx      <= ld_idx + 1;
            m_load_left <= m_load_left - 1;
         end else if (m_out_left > 0) begin
            m_ov       <= 1'b1;
            m_dout     <= 8'hA0 + 8'(m_out_left);
            m_out_left <= m_out_left - 1;
         end else begin
            m_ov   <= 1'b0;
            m_busy <= 1'b0;
         end
      end
   end

   // Event counters sampled at the active edge (values of the ending cycle).
   int   n_ack0 = 0, n_ack1 = 0, n_done0 = 0, n_done1 = 0;
   int   n_ov0 = 0, n_ov1 = 0, n_cv = 0, n_cvdbl = 0;
   logic prev_cv = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         if (ack0) n_ack0 <= n_ack0 + 1;
         if (ack1) n_ack1 <= n_ack1 + 1;
         if (done0) n_done0 <= n_done0 + 1;
         if (done1) n_done1 <= n_done1 + 1;
         if (out_valid0) n_ov0 <= n_ov0 + 1;
         if (out_valid1) n_ov1 <= n_ov1 + 1;
         if (lcd_cmd_valid) n_cv <= n_cv + 1;
         if (lcd_cmd_valid && prev_cv) n_cvdbl <= n_cvdbl + 1;
         prev_cv <= lcd_cmd_valid;
      end else begin
         prev_cv <= 1'b0;
      end
   end

   // Waits (sampling at negedge) for: 0 ack0, 1 ack1, 2 done0, 3 done1,
   // 4 out_valid0, 5 mem_addr==20, 6 any ack. cyc = negedges waited.
   task automatic wait_for(input int which, input int budget, output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         cyc = i + 1;
         case (which)
            0: ok = ack0;
            1: ok = ack1;
            2: ok = done0;
            3: ok = done1;
            4: ok = out_valid0;
            5: ok = (mem_addr == 6'd20);
            default: ok = ack0 | ack1;
         endcase
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({ack0, ack1, err0, err1, done0, done1, out_valid0, out_valid1, lcd_cmd_valid} !== 9'b0) begin
         failures++;
         $display("FAIL reset_pulses: got %b required 0", {ack0, ack1, err0, err1, done0, done1, out_valid0, out_valid1, lcd_cmd_valid});
      end
      checks++;
      if ({lcd_cmd, lcd_datain, mem_addr, mem_sel} !== 18'b0) begin
         failures++;
         $display("FAIL reset_regs: cmd=%0d datain=%0h addr=%0d sel=%0d required all 0", lcd_cmd, lcd_datain, mem_addr, mem_sel);
      end
      reset = 1'b0;
   endtask

   task automatic test_load();
      bit ok;
      int cyc, bad, ov0_b, ov1_b, cv_b;
      ov0_b = n_ov0; ov1_b = n_ov1; cv_b = n_cv;
      win_n = 9;
      cmd0 = 3'd1;
      req0 = 1'b1;
      wait_for(0, 20, ok, cyc);
      checks++;
      if (!ok || cyc != 1) begin
         failures++;
         $display("FAIL load_ack_latency: ok=%0d cycles=%0d required 1", ok, cyc);
      end
      checks++;
      if ({lcd_cmd_valid, lcd_cmd, mem_sel} !== 5'b10010) begin
         failures++;
         $display("FAIL load_issue: valid=%0d cmd=%0d sel=%0d required 1/1/0", lcd_cmd_valid, lcd_cmd, mem_sel);
      end
      req0 = 1'b0;
      wait_for(4, 80, ok, cyc);
      checks++;
      if (!ok || out_data !== 8'hA9) begin
         failures++;
         $display("FAIL load_out_data: ok=%0d data=%0h required a9", ok, out_data);
      end
      wait_for(2, 80, ok, cyc);
      checks++;
      if (!ok || err0 !== 1'b0) begin
         failures++;
         $display("FAIL load_done: ok=%0d err0=%0d required done with err0=0", ok, err0);
      end
      bad = 0;
      for (int i = 0; i < 36; i++) if (ld_buf[i] !== 8'(i)) bad++;
      checks++;
      if (ld_idx != 36 || bad != 0) begin
         failures++;
         $display("FAIL load_stream: bytes=%0d wrong=%0d required 36/0", ld_idx, bad);
      end
      checks++;
      if (n_ov0 - ov0_b != 9 || n_ov1 != ov1_b || n_cv - cv_b != 1) begin
         failures++;
         $display("FAIL load_counts: ov0=%0d ov1=%0d cv=%0d required 9/0/1", n_ov0 - ov0_b, n_ov1 - ov1_b, n_cv - cv_b);
      end
   endtask

   task automatic test_simul(input bit exp_first);
      bit ok, w;
      int cyc;
      cmd0 = 3'd0; cmd1 = 3'd0;
      req0 = 1'b1; req1 = 1'b1;
      wait_for(6, 40, ok, cyc);
      checks++;
      if (!ok || {ack1, ack0} !== (exp_first ? 2'b10 : 2'b01)) begin
         failures++;
         $display("FAIL simul_first: ok=%0d ack1ack0=%b required first=%0d", ok, {ack1, ack0}, exp_first);
      end
      w = ack1;
      if (w) req1 = 1'b0; else req0 = 1'b0;
      wait_for(w ? 3 : 2, 60, ok, cyc);
      checks++;
      if (!ok) begin failures++; $display("FAIL simul_done_first: timeout required done%0d", w); end
      wait_for(w ? 0 : 1, 20, ok, cyc);
      checks++;
      if (!ok) begin failures++; $display("FAIL simul_second_ack: timeout required ack%0d", !w); end
      if (w) req0 = 1'b0; else req1 = 1'b0;
      wait_for(w ? 2 : 3, 60, ok, cyc);
      checks++;
      if (!ok) begin failures++; $display("FAIL simul_done_second: timeout required done%0d", !w); end
   endtask

   task automatic test_move(input bit who, input logic [2:0] c);
      bit ok;
      int cyc, ov_b;
      @(negedge clk);
      ov_b = who ? n_ov1 : n_ov0;
      if (who) begin cmd1 = c; req1 = 1'b1; end else begin cmd0 = c; req0 = 1'b1; end
      wait_for(who ? 1 : 0, 20, ok, cyc);
      checks++;
      if (!ok || cyc != 1 || lcd_cmd !== c || lcd_cmd_valid !== 1'b1) begin
         failures++;
         $display("FAIL move_issue: ok=%0d cycles=%0d cmd=%0d required 1/%0d", ok, cyc, lcd_cmd, c);
      end
      req0 = 1'b0; req1 = 1'b0;
      wait_for(who ? 3 : 2, 60, ok, cyc);
      checks++;
      if (!ok || (who ? err1 : err0) !== 1'b0 || (who ? n_ov1 : n_ov0) - ov_b != 9) begin
         failures++;
         $display("FAIL move_done: ok=%0d err=%0d bytes=%0d required done, err 0, 9 bytes", ok, who ? err1 : err0, (who ? n_ov1 : n_ov0) - ov_b);
      end
   endtask

   task automatic test_illegal();
      bit ok, w;
      int cyc, cv_b;
      @(negedge clk);
      cv_b = n_cv;
      cmd1 = 3'd7;
      req1 = 1'b1;
      wait_for(1, 20, ok, cyc);
      checks++;
      if (!ok || err1 !== 1'b1 || lcd_cmd_valid !== 1'b0) begin
         failures++;
         $display("FAIL illegal_ack_err: ok=%0d err1=%0d cmd_valid=%0d required 1/1/0", ok, err1, lcd_cmd_valid);
      end
      req1 = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (n_cv != cv_b) begin
         failures++;
         $display("FAIL illegal_no_issue: cmd strobes=%0d required 0", n_cv - cv_b);
      end
      cmd0 = 3'd5; cmd1 = 3'd5;
      req0 = 1'b1; req1 = 1'b1;
      wait_for(6, 20, ok, cyc);
      checks++;
      if (!ok || {ack1, ack0} !== 2'b01) begin
         failures++;
         $display("FAIL illegal_next_prio: ack1ack0=%b required 01", {ack1, ack0});
      end
      w = ack1;
      if (w) req1 = 1'b0; else req0 = 1'b0;
      wait_for(w ? 3 : 2, 60, ok, cyc);
      wait_for(w ? 0 : 1, 20, ok, cyc);
      req0 = 1'b0; req1 = 1'b0;
      wait_for(w ? 2 : 3, 60, ok, cyc);
      checks++;
      if (!ok) begin failures++; $display("FAIL illegal_cleanup: timeout required done"); end
   endtask

   task automatic test_busy_block();
      bit ok;
      int cyc, ack_b;
      @(negedge clk);
      ack_b = n_ack0;
      busy_force = 1'b1;
      cmd0 = 3'd3;
      req0 = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (n_ack0 != ack_b || ack0 !== 1'b0) begin
         failures++;
         $display("FAIL busy_block: acks=%0d required 0", n_ack0 - ack_b);
      end
      busy_force = 1'b0;
      @(negedge clk);
      // busy fell mid-cycle; the ack appears in the following cycle
      checks++;
      if (ack0 !== 1'b1) begin
         failures++;
         $display("FAIL busy_release_ack: ack0=%0d required 1", ack0);
      end
      req0 = 1'b0;
      wait_for(2, 60, ok, cyc);
      checks++;
      if (!ok || err0 !== 1'b0) begin failures++; $display("FAIL busy_done: ok=%0d err0=%0d required 1/0", ok, err0); end
   endtask

   task automatic test_short();
      bit ok;
      int cyc, ov_b;
      @(negedge clk);
      ov_b = n_ov1;
      win_n = 8;
      cmd1 = 3'd4;
      req1 = 1'b1;
      wait_for(1, 20, ok, cyc);
      req1 = 1'b0;
      wait_for(3, 60, ok, cyc);
      checks++;
      if (!ok || err1 !== 1'b1 || err0 !== 1'b0) begin
         failures++;
         $display("FAIL short_err: ok=%0d err1=%0d err0=%0d required done1 with err1=1", ok, err1, err0);
      end
      checks++;
      if (n_ov1 - ov_b != 8) begin
         failures++;
         $display("FAIL short_bytes: got %0d required 8", n_ov1 - ov_b);
      end
      win_n = 9;
   endtask

   task automatic test_reset_mid_load();
      bit ok;
      int cyc, d_b;
      @(negedge clk);
      cmd1 = 3'd1;
      req1 = 1'b1;
      wait_for(1, 20, ok, cyc);
      req1 = 1'b0;
      wait_for(5, 40, ok, cyc);
      checks++;
      if (!ok || mem_sel !== 1'b1 || lcd_datain !== 8'h54) begin
         failures++;
         $display("FAIL midload_pre: ok=%0d sel=%0d datain=%0h required 1/1/54", ok, mem_sel, lcd_datain);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({ack0, ack1, err0, err1, done0, done1, out_valid0, out_valid1, lcd_cmd_valid, mem_sel} !== 10'b0 ||
          lcd_datain !== 8'h00 || mem_addr !== 6'd0) begin
         failures++;
         $display("FAIL midload_reset: datain=%0h addr=%0d sel=%0d required all 0", lcd_datain, mem_addr, mem_sel);
      end
      @(negedge clk);
      reset = 1'b0;
      d_b = n_done0 + n_done1;
      repeat (10) @(negedge clk);
      checks++;
      if (n_done0 + n_done1 != d_b) begin
         failures++;
         $display("FAIL midload_no_done: done pulses=%0d required 0", n_done0 + n_done1 - d_b);
      end
      test_move(1'b0, 3'd2);
   endtask

   initial begin
      test_reset();
      test_load();
      pulse_reset();
      test_simul(1'b0);
      test_move(1'b0, 3'd2);
      test_simul(1'b1);
      test_illegal();
      test_busy_block();
      test_short();
      test_reset_mid_load();
      checks++;
      if (n_cvdbl != 0) begin
         failures++;
         $display("FAIL cmd_valid_double: got %0d back-to-back strobes required 0", n_cvdbl);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
